// File: rtl/mem_pkg.sv
// Shared constants for the memory arbiter: MemOp encodings, FSM states,
// requester ids and the request legality helpers.
package mem_pkg;

  // MemOp encodings; 011, 110 and 111 are illegal.
  localparam logic [2:0] OP_LB  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LW  = 3'b010;
  localparam logic [2:0] OP_LBU = 3'b100;
  localparam logic [2:0] OP_LHU = 3'b101;

  // Requester ids, also used as the last_grant encoding.
  localparam logic REQ_IFU = 1'b0;
  localparam logic REQ_LSU = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  // True for the five defined MemOp codes.
  function automatic logic op_legal(input logic [2:0] op);
    case (op)
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: op_legal = 1'b1;
      default:                             op_legal = 1'b0;
    endcase
  endfunction

  // Halves need addr[0]=0, words need addr[1:0]=0; bytes are always aligned.
  function automatic logic op_misaligned(input logic [2:0] op, input logic [1:0] off);
    case (op[1:0])
      2'b01:   op_misaligned = off[0];
      2'b10:   op_misaligned = (off != 2'b00);
      default: op_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering between the 32-bit memory word and the requester:
// store data/mask placement and load extraction with sign/zero extension.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [31:0] wdata_sh,
  output logic [3:0]  wmask,
  output logic [31:0] rdata_ext
);

  logic [31:0] rdata_sh;
  logic [3:0]  base_mask;

  // Place store data and its lane mask at the addressed byte offset.
  always_comb begin
    case (op[1:0])
      2'b00:   base_mask = 4'b0001;
      2'b01:   base_mask = 4'b0011;
      default: base_mask = 4'b1111;
    endcase
    wdata_sh = wdata << {off, 3'b000};
    wmask    = base_mask << off;
  end

  // Bring the addressed bytes down to bit 0 and extend to 32 bits.
  always_comb begin
    rdata_sh = rdata >> {off, 3'b000};
    case (op)
      OP_LB:   rdata_ext = {{24{rdata_sh[7]}}, rdata_sh[7:0]};
      OP_LH:   rdata_ext = {{16{rdata_sh[15]}}, rdata_sh[15:0]};
      OP_LBU:  rdata_ext = {24'h000000, rdata_sh[7:0]};
      OP_LHU:  rdata_ext = {16'h0000, rdata_sh[15:0]};
      default: rdata_ext = rdata_sh;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter between the IFU and LSU in front of a single-port
// memory with fixed access latency. One request is in flight at a time.
// Handshake: a request transfers on a cycle where req_valid && req_ready;
// a response transfers on a cycle where resp_valid && resp_ready, and
// resp_data/resp_err stay stable while resp_valid is high.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req_valid,
  output logic        if_req_ready,
  input  logic [31:0] if_req_addr,
  output logic        if_resp_valid,
  input  logic        if_resp_ready,
  output logic [31:0] if_resp_data,
  output logic        if_resp_err,
  input  logic        ls_req_valid,
  output logic        ls_req_ready,
  input  logic [31:0] ls_req_addr,
  input  logic        ls_req_wen,
  input  logic [2:0]  ls_req_op,
  input  logic [31:0] ls_req_wdata,
  output logic        ls_resp_valid,
  input  logic        ls_resp_ready,
  output logic [31:0] ls_resp_data,
  output logic        ls_resp_err,
  output logic        mem_en,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic [31:0] mem_rdata
);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        last_grant_q, last_grant_d;
  logic        owner_q, owner_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  op_q, op_d;
  logic        wen_q, wen_d;
  logic [31:0] wdata_q, wdata_d;
  logic        first_q, first_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic        resp_err_q, resp_err_d;

  logic        grant_ifu, grant_lsu, accept;
  logic [31:0] new_addr, new_wdata;
  logic [2:0]  new_op;
  logic        new_wen, new_bad;
  logic        in_access, in_resp, owner_ready;
  logic [31:0] wdata_sh, rdata_ext;
  logic [3:0]  wmask;

  mem_lane_align u_lane_align (
    .op        (op_q),
    .off       (addr_q[1:0]),
    .wdata     (wdata_q),
    .rdata     (mem_rdata),
    .wdata_sh  (wdata_sh),
    .wmask     (wmask),
    .rdata_ext (rdata_ext)
  );

  // Round-robin grant, request mux and ready generation (IDLE only).
  always_comb begin
    grant_ifu    = if_req_valid && (!ls_req_valid || (last_grant_q == REQ_LSU));
    grant_lsu    = ls_req_valid && !grant_ifu;
    if_req_ready = rst_n && (state_q == ST_IDLE) && grant_ifu;
    ls_req_ready = rst_n && (state_q == ST_IDLE) && grant_lsu;
    accept       = if_req_ready || ls_req_ready;
    new_addr     = grant_ifu ? if_req_addr : ls_req_addr;
    new_op       = grant_ifu ? OP_LW : ls_req_op;
    new_wen      = grant_ifu ? 1'b0 : ls_req_wen;
    new_wdata    = grant_ifu ? 32'h0 : ls_req_wdata;
    new_bad      = !op_legal(new_op) || op_misaligned(new_op, new_addr[1:0]);
    owner_ready  = (owner_q == REQ_IFU) ? if_resp_ready : ls_resp_ready;
  end

  // Next-state logic for the FSM, latency counter, latches and response.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    addr_d       = addr_q;
    op_d         = op_q;
    wen_d        = wen_q;
    wdata_d      = wdata_q;
    first_d      = first_q;
    resp_data_d  = resp_data_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          last_grant_d = grant_ifu ? REQ_IFU : REQ_LSU;
          owner_d      = grant_ifu ? REQ_IFU : REQ_LSU;
          addr_d       = new_addr;
          op_d         = new_op;
          wen_d        = new_wen;
          wdata_d      = new_wdata;
          if (new_bad) begin
            state_d     = ST_RESP;
            resp_data_d = 32'h0;
            resp_err_d  = 1'b1;
          end else begin
            state_d = ST_ACCESS;
            cnt_d   = 4'(LATENCY - 1);
            first_d = 1'b1;
          end
        end
      end
      ST_ACCESS: begin
        first_d = 1'b0;
        if (cnt_q == 4'd0) begin
          state_d     = ST_RESP;
          resp_data_d = wen_q ? 32'h0 : rdata_ext;
          resp_err_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (owner_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset aborts any access and discards a pending response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      last_grant_q <= REQ_LSU;
      owner_q      <= REQ_IFU;
      addr_q       <= 32'h0;
      op_q         <= 3'b000;
      wen_q        <= 1'b0;
      wdata_q      <= 32'h0;
      first_q      <= 1'b0;
      resp_data_q  <= 32'h0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      addr_q       <= addr_d;
      op_q         <= op_d;
      wen_q        <= wen_d;
      wdata_q      <= wdata_d;
      first_q      <= first_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Memory and response outputs, decoded from registered state only.
  always_comb begin
    in_access     = (state_q == ST_ACCESS);
    in_resp       = (state_q == ST_RESP);
    mem_en        = in_access;
    mem_wen       = in_access && wen_q && first_q;
    mem_addr      = in_access ? {addr_q[31:2], 2'b00} : 32'h0;
    mem_wdata     = mem_wen ? wdata_sh : 32'h0;
    mem_wmask     = mem_wen ? wmask : 4'b0000;
    if_resp_valid = in_resp && (owner_q == REQ_IFU);
    ls_resp_valid = in_resp && (owner_q == REQ_LSU);
    if_resp_data  = if_resp_valid ? resp_data_q : 32'h0;
    if_resp_err   = if_resp_valid && resp_err_q;
    ls_resp_data  = ls_resp_valid ? resp_data_q : 32'h0;
    ls_resp_err   = ls_resp_valid && resp_err_q;
  end

endmodule
